// File: rtl/base_vdelay.sv
// base_vdelay: valid-qualified, stallable delay line with a run-time selectable
// delay of 0..max_n advancing cycles. A delay of 0 is a combinational bypass.
// A delay change is taken only when no valid word is inside the active window.
// On a change every stage valid bit is cleared, so words from an old window are
// never emitted.
// Optional feature, enabled by defining BASE_VDELAY_FLUSH_EN: adds port i_flush,
// which clears all in-flight valid bits on the next edge.
module base_vdelay #(
    parameter int unsigned width  = 1,
    parameter int unsigned max_n  = 4,
    parameter int unsigned init_n = 1
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef BASE_VDELAY_FLUSH_EN
    input  logic                         i_flush,
`endif
    input  logic                         i_en,
    input  logic                         i_v,
    input  logic [0:width-1]             i_d,
    input  logic                         i_sel_v,
    input  logic [$clog2(max_n+1)-1:0]   i_sel,
    output logic                         o_v,
    output logic [0:width-1]             o_d,
    output logic [$clog2(max_n+1)-1:0]   o_n,
    output logic                         o_busy
);

    localparam int unsigned sel_w = $clog2(max_n + 1);

    // Stage storage: valid bits packed, data words as an unpacked array.
    logic [max_n-1:0]  stage_v;
    logic [0:width-1]  stage_d [max_n];
    logic [sel_w-1:0]  n_q;

    logic [max_n-1:0]  v_nxt;
    logic [0:width-1]  d_nxt [max_n];
    logic [sel_w-1:0]  n_nxt;

    logic              flush_c;
    logic              busy_c;
    logic              sel_ok_c;
    logic              accept_c;

`ifdef BASE_VDELAY_FLUSH_EN
    assign flush_c = i_flush;
`else
    assign flush_c = 1'b0;
`endif

    // Any valid word inside the active window s[0..n-1].
    always_comb begin
        busy_c = 1'b0;
        for (int unsigned k = 0; k < max_n; k++) begin
            if (sel_w'(k) < n_q) begin
                busy_c = busy_c | stage_v[k];
            end
        end
    end

    // Delay change acceptance; a flush empties the window so busy is moot.
    always_comb begin
        sel_ok_c = (i_sel <= sel_w'(max_n));
        accept_c = i_sel_v && sel_ok_c && (flush_c || !busy_c);
    end

    // Next stage contents: shift on advance, then apply flush / change clearing.
    always_comb begin
        v_nxt = stage_v;
        for (int unsigned k = 0; k < max_n; k++) begin
            d_nxt[k] = stage_d[k];
        end
        if (i_en) begin
            for (int unsigned k = 1; k < max_n; k++) begin
                v_nxt[k] = stage_v[k-1];
                d_nxt[k] = stage_d[k-1];
            end
            v_nxt[0] = i_v;
            d_nxt[0] = i_d;
        end
        if (flush_c) begin
            v_nxt = '0;
        end else if (accept_c) begin
            v_nxt    = '0;
            v_nxt[0] = i_v & i_en;
        end
        n_nxt = accept_c ? i_sel : n_q;
    end

    // Stage and delay registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_v <= '0;
            for (int unsigned k = 0; k < max_n; k++) begin
                stage_d[k] <= '0;
            end
            n_q <= sel_w'(init_n);
        end else begin
            stage_v <= v_nxt;
            for (int unsigned k = 0; k < max_n; k++) begin
                stage_d[k] <= d_nxt[k];
            end
            n_q <= n_nxt;
        end
    end

    // Output tap select: bypass for delay 0, else stage n-1.
    always_comb begin
        o_v = 1'b0;
        o_d = '0;
        if (n_q == '0) begin
            o_v = i_v & i_en;
            o_d = i_d;
        end else begin
            for (int unsigned k = 0; k < max_n; k++) begin
                if (n_q == sel_w'(k + 1)) begin
                    o_v = stage_v[k];
                    o_d = stage_d[k];
                end
            end
        end
    end

    assign o_n    = n_q;
    assign o_busy = busy_c;

`ifndef SYNTHESIS
    // Shadow history of every presented word, advanced only on i_en, used to
    // confirm a tap output really is the word presented n advances earlier.
    logic [width:0] hist [max_n];
    logic [width:0] hist_tap_c;

    // History shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < max_n; k++) begin
                hist[k] <= '0;
            end
        end else if (i_en) begin
            hist[0] <= {i_v, i_d};
            for (int unsigned k = 1; k < max_n; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    // History entry matching the active delay.
    always_comb begin
        hist_tap_c = '0;
        for (int unsigned k = 0; k < max_n; k++) begin
            if (n_q == sel_w'(k + 1)) begin
                hist_tap_c = hist[k];
            end
        end
    end

    // A valid tap output must equal the presented word n advances ago.
    always @(posedge clk) begin
        if (reset && (n_q != '0) && o_v) begin
            assert (hist_tap_c == {1'b1, o_d});
        end
    end
`endif

endmodule

// File: tb/tb_base_vdelay.sv
// Directed bench for base_vdelay (width=8, max_n=4, init_n=1).
module tb_base_vdelay;

    localparam int unsigned W     = 8;
    localparam int unsigned MAXN  = 4;
    localparam int unsigned INITN = 1;
    localparam int unsigned SW    = $clog2(MAXN + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
`ifdef BASE_VDELAY_FLUSH_EN
    logic          i_flush = 1'b0;
`endif
    logic          i_en = 1'b0;
    logic          i_v = 1'b0;
    logic [W-1:0]  i_d = '0;
    logic          i_sel_v = 1'b0;
    logic [SW-1:0] i_sel = '0;
    logic          o_v;
    logic [W-1:0]  o_d;
    logic [SW-1:0] o_n;
    logic          o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    base_vdelay #(.width(W), .max_n(MAXN), .init_n(INITN)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef BASE_VDELAY_FLUSH_EN
        .i_flush (i_flush),
`endif
        .i_en    (i_en),
        .i_v     (i_v),
        .i_d     (i_d),
        .i_sel_v (i_sel_v),
        .i_sel   (i_sel),
        .o_v     (o_v),
        .o_d     (o_d),
        .o_n     (o_n),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic v, input logic [W-1:0] d);
        i_en = en;
        i_v  = v;
        i_d  = d;
        #1;
    endtask

    task automatic req(input logic sv, input logic [SW-1:0] s);
        i_sel_v = sv;
        i_sel   = s;
        #1;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_o_v", 32'(o_v), 0);
        chk("rst_o_d", 32'(o_d), 0);
        chk("rst_o_n", 32'(o_n), INITN);
        chk("rst_busy", 32'(o_busy), 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rel_o_v", 32'(o_v), 0);
        chk("rel_o_n", 32'(o_n), 1);

        // Burst with delay 1
        drive(1, 1, 8'hA5);
        chk("b_pre_v", 32'(o_v), 0);
        tick();
        drive(1, 1, 8'h3C);
        chk("b0_v", 32'(o_v), 1);
        chk("b0_d", 32'(o_d), 32'hA5);
        chk("b0_busy", 32'(o_busy), 1);
        tick();
        drive(1, 1, 8'h0F);
        chk("b1_v", 32'(o_v), 1);
        chk("b1_d", 32'(o_d), 32'h3C);
        chk("b1_busy", 32'(o_busy), 1);
        tick();
        drive(1, 0, 8'h00);
        chk("b2_v", 32'(o_v), 1);
        chk("b2_d", 32'(o_d), 32'h0F);
        tick();
        chk("b3_v", 32'(o_v), 0);
        chk("b3_busy", 32'(o_busy), 0);

        // Change to delay 3, then stalled word
        req(1, 3);
        tick();
        req(0, 0);
        chk("n3", 32'(o_n), 3);
        drive(1, 1, 8'h11);
        chk("s_c1_v", 32'(o_v), 0);
        tick();
        drive(0, 0, 8'h00);
        chk("s_c2_v", 32'(o_v), 0);
        chk("s_c2_busy", 32'(o_busy), 1);
        tick();
        drive(1, 0, 8'h00);
        chk("s_c3_v", 32'(o_v), 0);
        tick();
        chk("s_c4_v", 32'(o_v), 0);
        chk("s_c4_busy", 32'(o_busy), 1);
        tick();
        chk("s_out_v", 32'(o_v), 1);
        chk("s_out_d", 32'(o_d), 32'h11);

        // Request delay 4 while busy: ignored until the word drains
        drive(0, 0, 8'h00);
        req(1, 4);
        tick();
        chk("busy_n_hold", 32'(o_n), 3);
        chk("busy_v_hold", 32'(o_v), 1);
        drive(1, 0, 8'h00);
        tick();
        chk("drain_n", 32'(o_n), 3);
        chk("drain_busy", 32'(o_busy), 0);
        chk("drain_v", 32'(o_v), 0);
        drive(1, 1, 8'h22);
        tick();
        req(0, 0);
        drive(1, 0, 8'h00);
        chk("n4", 32'(o_n), 4);
        chk("n4_a1_v", 32'(o_v), 0);
        tick();
        chk("n4_a2_v", 32'(o_v), 0);
        tick();
        chk("n4_a3_v", 32'(o_v), 0);
        tick();
        chk("n4_a4_v", 32'(o_v), 1);
        chk("n4_a4_d", 32'(o_d), 32'h22);
        tick();
        chk("n4_a5_v", 32'(o_v), 0);
        chk("n4_a5_busy", 32'(o_busy), 0);

        // Delay 0 bypass
        req(1, 0);
        tick();
        req(0, 0);
        chk("n0", 32'(o_n), 0);
        drive(1, 1, 8'h5A);
        chk("byp_v", 32'(o_v), 1);
        chk("byp_d", 32'(o_d), 32'h5A);
        chk("byp_busy", 32'(o_busy), 0);
        drive(0, 1, 8'h5A);
        chk("byp_stall_v", 32'(o_v), 0);
        drive(1, 1, 8'h6B);
        tick();
        chk("byp_busy2", 32'(o_busy), 0);
        chk("byp_d2", 32'(o_d), 32'h6B);

        // Fill under delay 1, leave stale words, then widen to 4
        drive(1, 0, 8'h00);
        req(1, 1);
        tick();
        req(0, 0);
        chk("n1", 32'(o_n), 1);
        drive(1, 1, 8'h61);
        tick();
        drive(1, 1, 8'h62);
        tick();
        drive(1, 1, 8'h63);
        tick();
        drive(1, 1, 8'h64);
        tick();
        drive(1, 0, 8'h00);
        chk("fill_v", 32'(o_v), 1);
        chk("fill_d", 32'(o_d), 32'h64);
        chk("fill_busy", 32'(o_busy), 1);
        tick();
        chk("stale_busy", 32'(o_busy), 0);
        req(1, 7);
        tick();
        chk("sel7_ignored", 32'(o_n), 1);
        req(1, 4);
        tick();
        req(0, 0);
        chk("wide_n", 32'(o_n), 4);
        chk("wide_a1_v", 32'(o_v), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wide_stale_v", 32'(o_v), 0);
        end

        // Reset mid-burst
        drive(1, 1, 8'h71);
        tick();
        drive(1, 1, 8'h72);
        tick();
        chk("rb_busy", 32'(o_busy), 1);
        reset = 1'b0;
        drive(1, 0, 8'h00);
        chk("rb_in_v", 32'(o_v), 0);
        chk("rb_in_busy", 32'(o_busy), 0);
        chk("rb_in_n", 32'(o_n), INITN);
        tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rb_after_v", 32'(o_v), 0);
            chk("rb_after_busy", 32'(o_busy), 0);
        end
        chk("rb_after_n", 32'(o_n), 1);

`ifdef BASE_VDELAY_FLUSH_EN
        // Flush mid-burst under delay 3, together with an accepted change to 2
        req(1, 3);
        tick();
        req(0, 0);
        drive(1, 1, 8'h81);
        tick();
        drive(1, 1, 8'h82);
        tick();
        chk("fl_busy_pre", 32'(o_busy), 1);
        i_flush = 1'b1;
        req(1, 2);
        drive(1, 1, 8'h83);
        tick();
        i_flush = 1'b0;
        req(0, 0);
        drive(1, 0, 8'h00);
        chk("fl_n", 32'(o_n), 2);
        chk("fl_busy", 32'(o_busy), 0);
        chk("fl_v", 32'(o_v), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fl_after_v", 32'(o_v), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
